dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the data memory. Port 0 is the pipeline MEM stage; port 1 is the debug/program-loader port. It selects one request per cycle and registers it into an issue stage that drives the memory's MemRead/MemWrite/address/write-data/Funct3 inputs. It captures read data and returns a tagged response to the winning requester. Port 1 is protected against starvation and may lock the memory for bursts.

Parameters:
DM_ADDRESS, 9, byte-address width driven to the memory.
DATA_W, 32, data width.
MAX_WAIT, 4, cycles port 1 may wait while port 0 keeps winning before port 1 is forced to win (1..15).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
p0_req / p1_req  in  1  request; held with its fields stable until the matching gnt
p0_we / p1_we  in  1  1 = store, 0 = load
p0_addr / p1_addr  in  DM_ADDRESS  byte address
p0_wdata / p1_wdata  in  DATA_W  store data
p0_funct3 / p1_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW)
p1_lock  in  1  port 1 requests exclusive ownership
p0_gnt / p1_gnt  out  1  combinational accept pulse; the request is consumed on this edge
p0_rvalid / p1_rvalid  out  1  one-cycle response pulse, for loads and stores
p0_rdata / p1_rdata  out  DATA_W  load data, valid with rvalid; 0 for stores
p0_err / p1_err  out  1  misaligned-access flag, valid with rvalid
mem_read, mem_write  out  1  to memory MemRead/MemWrite
mem_a  out  DM_ADDRESS  to memory address
mem_wd  out  DATA_W  to memory write data
mem_funct3  out  3  to memory Funct3
mem_rd  in  DATA_W  memory read data, valid during the issue cycle

Behaviour:
- Reset (async): state ARB, issue register invalid, wait counter 0.
  - All gnt, rvalid, err, mem_read and mem_write are 0; rdata, mem_a, mem_wd and mem_funct3 are 0.
  - A reset during an in-flight access drops it silently; no rvalid follows.
- Pipeline timing: cycle T is gnt (request latched into issue register); T+1 is issue (mem_* driven, mem_rd captured at the edge ending T+1); T+2 has rvalid/rdata/err on the granted port only.
  - Load latency is 2 cycles after gnt.
  - Throughput is one access per cycle; back-to-back gnts are allowed.
- mem_read = issue_valid & ~we; mem_write = issue_valid & we; the two are never both 1.
  - With no valid issue, mem_read, mem_write and mem_wd are 0.
- States:
  - ARB (normal arbitration).
  - LOCK1 (port 1 owns the memory).
- ARB winner selection:
  - Only p0_req: p0 wins.
  - Only p1_req: p1 wins.
  - Both requesting: p0 wins unless wait_cnt == MAX_WAIT, in which case p1 wins.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle p1_req=1 and p1_gnt=0.
  - Clears on p1_gnt.
  - Holds when p1_req=0.
- ARB -> LOCK1 when p1 is granted with p1_lock=1.
- LOCK1:
  - Only port 1 can win; p0_gnt=0 regardless of p0_req.
  - Exits to ARB on the first edge with p1_lock=0. That cycle is still arbitrated as LOCK1, so p0 cannot win until the following cycle.
- A request that is not granted must stay asserted. The arbiter never grants the same request twice.
- Response routing uses a port-id bit carried in the issue register.

Optional Feature:
- Macro DMEM_ARB_MISALIGN_CHECK_EN.
- Defined:
  - At gnt, misalignment is detected as LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - A misaligned request is still granted and occupies the issue slot, but mem_read and mem_write stay 0.
  - Its response has err=1 and rdata=0.
- Undefined: no check is made; requests are issued unchanged and p0_err/p1_err are tied 0.

Decomposition:
- Package dmem_arb_pkg contains:
  - funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
  - enum arb_state_e {ARB, LOCK1}.
  - enum port_id_e {PORT_PIPE, PORT_DBG}.
  - packed struct issue_t {valid, port, we, addr, wdata, funct3, err}.
- One sub-module, dmem_arb_select: combinational winner selection from req bits, state and wait_cnt.
- Counter, FSM and issue/response registers stay in the top.

Test Plan:
- Single p0 LW: addr=0x010, memory preloaded with 0xDEADBEEF -> p0_gnt at T, mem_read=1 at T+1, p0_rvalid=1 with p0_rdata=0xDEADBEEF at T+2, p1_rvalid=0.
- Both ports request every cycle for 12 cycles with MAX_WAIT=4 -> p0 wins 4 cycles, p1 wins in cycle 5, the counter clears, and the pattern repeats.
- p1 SW burst with p1_lock=1 for 3 words at 0x020/0x024/0x028 while p0_req=1 -> three consecutive p1_gnt, p0_gnt=0 throughout, p0 granted one cycle after p1_lock falls.
- Back-to-back p0 SB 0xAB to 0x003, then LBU 0x003 -> gnts in consecutive cycles, load returns 0x000000AB.
- Assert reset while a load sits in the issue stage -> mem_read drops immediately, no rvalid follows, and the FSM is in ARB after release.
- With DMEM_ARB_MISALIGN_CHECK_EN: p0 LW at 0x006 -> gnt, mem_read stays 0, p0_rvalid with p0_err=1 and p0_rdata=0. Without the macro: mem_read=1 and err=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`timescale 1ns/1ps
// dmem_arb_pkg: shared types, funct3 encodings and helpers for the data-memory
// arbiter. The issue_t field widths must match the DM_ADDRESS/DATA_W
// parameters used on dmem_arbiter.
package dmem_arb_pkg;

    localparam int ISSUE_AW = 9;
    localparam int ISSUE_DW = 32;
    localparam int WAIT_W   = 4;

    // RISC-V load/store funct3 encodings (stores reuse the low load codes)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_PIPE = 1'b0,
        PORT_DBG  = 1'b1
    } port_id_e;

    typedef struct packed {
        logic                valid;
        port_id_e            port;
        logic                we;
        logic [ISSUE_AW-1:0] addr;
        logic [ISSUE_DW-1:0] wdata;
        logic [2:0]          funct3;
        logic                err;
    } issue_t;

    localparam int     ISSUE_W    = $bits(issue_t);
    localparam issue_t ISSUE_IDLE = issue_t'({ISSUE_W{1'b0}});

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    // SH/SW share the LH/LW encodings, so they are covered by the same items.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
        logic bad;
        case (f3)
            F3_LH, F3_LHU: bad = a_lo[0];
            F3_LW:         bad = (a_lo != 2'b00);
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_arb_select.sv
`timescale 1ns/1ps
// dmem_arb_select: combinational winner selection between the pipeline port
// (p0) and the debug/loader port (p1), given the FSM state and the p1 wait count.
module dmem_arb_select
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              p0_req,
    input  logic              p1_req,
    input  arb_state_e        state,
    input  logic [WAIT_W-1:0] wait_cnt,
    output logic              p0_win,
    output logic              p1_win
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // Pick at most one winner; p0 has priority unless p1 has waited long enough
    always_comb begin
        p0_win = 1'b0;
        p1_win = 1'b0;
        case (state)
            ARB: begin
                if (p0_req && p1_req) begin
                    if (wait_cnt == MAX_WAIT_C) begin
                        p1_win = 1'b1;
                    end else begin
                        p0_win = 1'b1;
                    end
                end else begin
                    p0_win = p0_req;
                    p1_win = p1_req;
                end
            end
            LOCK1: begin
                p0_win = 1'b0;
                p1_win = p1_req;
            end
            default: begin
                p0_win = 1'b0;
                p1_win = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: two-port arbiter/sequencer in front of the data memory.
// gnt at T, memory access (issue) at T+1, tagged response at T+2.
// Optional build macro DMEM_ARB_MISALIGN_CHECK_EN: flags misaligned LH/LHU/SH
// and LW/SW at grant, suppresses the memory access and returns err=1.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [2:0]            p0_funct3,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [2:0]            p1_funct3,
    input  logic                  p1_lock,
    output logic                  p0_gnt,
    output logic                  p1_gnt,
    output logic                  p0_rvalid,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p0_err,
    output logic                  p1_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    arb_state_e        state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    issue_t            issue_r;
    issue_t            win_s;
    logic              p0_win_s;
    logic              p1_win_s;
    logic              access_s;

    logic              p0_rvalid_r;
    logic              p1_rvalid_r;
    logic [DATA_W-1:0] p0_rdata_r;
    logic [DATA_W-1:0] p1_rdata_r;
    logic              p0_err_r;
    logic              p1_err_r;

    dmem_arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_select (
        .p0_req   (p0_req),
        .p1_req   (p1_req),
        .state    (state_r),
        .wait_cnt (wait_cnt_r),
        .p0_win   (p0_win_s),
        .p1_win   (p1_win_s)
    );

    // Nothing is accepted while reset is held
    assign p0_gnt = p0_win_s & ~reset;
    assign p1_gnt = p1_win_s & ~reset;

    // Build the issue-stage entry for the winning request
    always_comb begin
        win_s = ISSUE_IDLE;
        if (p1_win_s) begin
            win_s.valid  = 1'b1;
            win_s.port   = PORT_DBG;
            win_s.we     = p1_we;
            win_s.addr   = p1_addr;
            win_s.wdata  = p1_wdata;
            win_s.funct3 = p1_funct3;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
            win_s.err    = is_misaligned(p1_funct3, p1_addr[1:0]);
`else
            win_s.err    = 1'b0;
`endif
        end else if (p0_win_s) begin
            win_s.valid  = 1'b1;
            win_s.port   = PORT_PIPE;
            win_s.we     = p0_we;
            win_s.addr   = p0_addr;
            win_s.wdata  = p0_wdata;
            win_s.funct3 = p0_funct3;
`ifdef DMEM_ARB_MISALIGN_CHECK_EN
            win_s.err    = is_misaligned(p0_funct3, p0_addr[1:0]);
`else
            win_s.err    = 1'b0;
`endif
        end else begin
            win_s = ISSUE_IDLE;
        end
    end

    // Arbitration FSM and p1 starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ARB;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ARB: begin
                    if (p1_win_s && p1_lock) begin
                        state_r <= LOCK1;
                    end else begin
                        state_r <= ARB;
                    end
                end
                LOCK1: begin
                    if (!p1_lock) begin
                        state_r <= ARB;
                    end else begin
                        state_r <= LOCK1;
                    end
                end
                default: state_r <= ARB;
            endcase

            if (p1_win_s) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (p1_req && (wait_cnt_r != MAX_WAIT_C)) begin
                wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Issue register: holds the access being presented to memory this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_r <= ISSUE_IDLE;
        end else begin
            issue_r <= win_s;
        end
    end

    // A flagged (misaligned) entry occupies the slot but never touches memory
    assign access_s   = issue_r.valid & ~issue_r.err;
    assign mem_read   = access_s & ~issue_r.we;
    assign mem_write  = access_s & issue_r.we;
    assign mem_a      = issue_r.addr;
    assign mem_funct3 = issue_r.funct3;
    assign mem_wd     = mem_write ? issue_r.wdata : {DATA_W{1'b0}};

    // Capture memory read data and route the response to the issuing port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= {DATA_W{1'b0}};
            p1_rdata_r  <= {DATA_W{1'b0}};
            p0_err_r    <= 1'b0;
            p1_err_r    <= 1'b0;
        end else begin
            p0_rvalid_r <= issue_r.valid & (issue_r.port == PORT_PIPE);
            p1_rvalid_r <= issue_r.valid & (issue_r.port == PORT_DBG);
            p0_rdata_r  <= (mem_read && (issue_r.port == PORT_PIPE)) ? mem_rd : {DATA_W{1'b0}};
            p1_rdata_r  <= (mem_read && (issue_r.port == PORT_DBG))  ? mem_rd : {DATA_W{1'b0}};
            p0_err_r    <= issue_r.valid & issue_r.err & (issue_r.port == PORT_PIPE);
            p1_err_r    <= issue_r.valid & issue_r.err & (issue_r.port == PORT_DBG);
        end
    end

    assign p0_rvalid = p0_rvalid_r;
    assign p1_rvalid = p1_rvalid_r;
    assign p0_rdata  = p0_rdata_r;
    assign p1_rdata  = p1_rdata_r;
    assign p0_err    = p0_err_r;
    assign p1_err    = p1_err_r;

endmodule
